// File: rtl/psum_spad_ctrl.sv
// Partial-sum scratchpad sequencer: signed saturating read-modify-write
// accumulation of MAC results and a valid/ready drain of the first n entries.
module psum_spad_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mac_valid,
  output logic              mac_ready,
  input  logic [DATA_W-1:0] mac_data,
  input  logic [ADDR_W-1:0] mac_addr,
  input  logic              mac_first,
  input  logic              drain_start,
  input  logic [ADDR_W:0]   cfg_num_psum,
  output logic              psum_out_valid,
  input  logic              psum_out_ready,
  output logic [DATA_W-1:0] psum_out_data,
  output logic              psum_out_last,
  output logic              drain_done,
  output logic              busy,
  output logic              spad_rd,
  output logic              spad_wr,
  output logic [ADDR_W-1:0] spad_addr,
  output logic [DATA_W-1:0] spad_wdata,
  input  logic [DATA_W-1:0] spad_rdata
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ACC_RD    = 3'd1;
  localparam logic [2:0] S_ACC_WR    = 3'd2;
  localparam logic [2:0] S_DRAIN_RD  = 3'd3;
  localparam logic [2:0] S_DRAIN_OUT = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);
  localparam logic [DATA_W-1:0] SAT_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] op_data_q, op_data_d;
  logic [ADDR_W-1:0] op_addr_q, op_addr_d;
  logic              op_first_q, op_first_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   num_q, num_d;

  logic [ADDR_W:0]   num_clamped;
  logic              drain_last;
  logic              mac_accept;
  logic [DATA_W:0]   acc_sum;
  logic [DATA_W-1:0] acc_sat;

  assign num_clamped = (cfg_num_psum > DEPTH_CNT) ? DEPTH_CNT : cfg_num_psum;
  assign drain_last  = ({1'b0, idx_q} == (num_q - CNT_ONE));
  assign mac_accept  = mac_valid && mac_ready;

  // One extra sign bit is enough to detect overflow of an 8+8 bit signed add.
  assign acc_sum = {spad_rdata[DATA_W-1], spad_rdata} + {op_data_q[DATA_W-1], op_data_q};

  always_comb begin
    acc_sat = acc_sum[DATA_W-1:0];
    if (acc_sum[DATA_W] != acc_sum[DATA_W-1]) begin
      acc_sat = acc_sum[DATA_W] ? SAT_MIN : SAT_MAX;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_data_d  = op_data_q;
    op_addr_d  = op_addr_q;
    op_first_d = op_first_q;
    idx_d      = idx_q;
    num_d      = num_q;
    case (state_q)
      S_IDLE: begin
        if (drain_start) begin
          num_d   = num_clamped;
          idx_d   = '0;
          state_d = (num_clamped == '0) ? S_DONE : S_DRAIN_RD;
        end else if (mac_accept) begin
          op_data_d  = mac_data;
          op_addr_d  = mac_addr;
          op_first_d = mac_first;
          state_d    = mac_first ? S_ACC_WR : S_ACC_RD;
        end
      end
      S_ACC_RD:   state_d = S_ACC_WR;
      S_ACC_WR:   state_d = S_IDLE;
      S_DRAIN_RD: state_d = S_DRAIN_OUT;
      S_DRAIN_OUT: begin
        if (psum_out_ready) begin
          if (drain_last) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = S_DRAIN_RD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_data_q  <= '0;
      op_addr_q  <= '0;
      op_first_q <= 1'b0;
      idx_q      <= '0;
      num_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_data_q  <= op_data_d;
      op_addr_q  <= op_addr_d;
      op_first_q <= op_first_d;
      idx_q      <= idx_d;
      num_q      <= num_d;
    end
  end

  // mac_ready is gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    mac_ready      = 1'b0;
    psum_out_valid = 1'b0;
    psum_out_data  = '0;
    psum_out_last  = 1'b0;
    drain_done     = 1'b0;
    busy           = (state_q != S_IDLE);
    spad_rd        = 1'b0;
    spad_wr        = 1'b0;
    spad_addr      = '0;
    spad_wdata     = '0;
    case (state_q)
      S_IDLE: mac_ready = rst_n && !drain_start;
      S_ACC_RD: begin
        spad_rd   = 1'b1;
        spad_addr = op_addr_q;
      end
      S_ACC_WR: begin
        spad_wr    = 1'b1;
        spad_addr  = op_addr_q;
        spad_wdata = op_first_q ? op_data_q : acc_sat;
      end
      S_DRAIN_RD: begin
        spad_rd   = 1'b1;
        spad_addr = idx_q;
      end
      S_DRAIN_OUT: begin
        psum_out_valid = 1'b1;
        psum_out_data  = spad_rdata;
        psum_out_last  = drain_last;
      end
      S_DONE:  drain_done = 1'b1;
      default: ;
    endcase
  end

endmodule
